// File: rtl/alarm_ctrl.sv
// Alarm controller for a BCD digital watch.
//
// Stores an alarm time and compares it with the current time from the watch.
// When the minute of the alarm is entered, the controller rings until stop,
// snooze or timeout. A snooze re-arms the ring SNOOZE_MIN minutes later, up to
// SNOOZE_MAX times per alarm event.
//
// Ports:
//   clk, rstn             rising-edge clock, synchronous active-low reset
//   tick_sec              one-cycle pulse per second
//   *_now                 current time, BCD digits (HH:MM)
//   *_set, set_load       alarm time to load, load strobe
//   alarm_en              level, arms the alarm
//   btn_snooze, btn_stop  debounced levels, acted on at their rising edges
//   ring                  high while ringing
//   *_alm                 stored alarm time, BCD digits
//   state                 0 idle, 1 armed, 2 ringing, 3 snooze
//   set_err               one-cycle pulse after a rejected load
module alarm_ctrl #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned SNOOZE_MAX = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick_sec,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  input  logic [3:0] hourdec_set,
  input  logic [3:0] hourone_set,
  input  logic [3:0] mindec_set,
  input  logic [3:0] minone_set,
  input  logic       set_load,
  input  logic       alarm_en,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic       ring,
  output logic [3:0] hourdec_alm,
  output logic [3:0] hourone_alm,
  output logic [3:0] mindec_alm,
  output logic [3:0] minone_alm,
  output logic [1:0] state,
  output logic       set_err
);

  localparam logic [7:0] RingSec = 8'(RING_SEC);
  localparam logic [3:0] SnzMin  = 4'(SNOOZE_MIN);
  localparam logic [3:0] SnzMax  = 4'(SNOOZE_MAX);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StRinging = 2'd2,
    StSnooze  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] alm_hd_q, alm_hd_d, alm_ho_q, alm_ho_d;
  logic [3:0] alm_md_q, alm_md_d, alm_mo_q, alm_mo_d;
  logic [3:0] snz_hd_q, snz_hd_d, snz_ho_q, snz_ho_d;
  logic [3:0] snz_md_q, snz_md_d, snz_mo_q, snz_mo_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic [3:0] snz_cnt_q, snz_cnt_d;
  logic       match_q, snz_btn_q, stp_btn_q;
  logic       ring_q, ring_d, set_err_q, set_err_d;

  logic       set_valid, load_ok;
  logic       snz_edge, stp_edge, timeout;
  logic       match, match_edge;
  logic [3:0] tgt_hd, tgt_ho, tgt_md, tgt_mo;

  // Snooze target = now + SNOOZE_MIN, computed digit by digit in BCD
  logic [4:0] mo_sum;
  logic [3:0] md_sum;
  logic       c_min, c_hr;
  logic [3:0] add_hd, add_ho, add_md, add_mo;

  assign set_valid = (hourdec_set <= 4'd2) && (hourone_set <= 4'd9) &&
                     ((hourdec_set < 4'd2) || (hourone_set <= 4'd3)) &&
                     (mindec_set <= 4'd5) && (minone_set <= 4'd9);
  assign load_ok   = set_load && set_valid;

  assign snz_edge = btn_snooze && !snz_btn_q;
  assign stp_edge = btn_stop && !stp_btn_q;
  assign timeout  = (state_q == StRinging) && (ring_cnt_q >= RingSec);

  // Outside SNOOZE the alarm time is the target. Keeping it during RINGING holds
  // match high through the ring, so returning to ARMED in the same minute does
  // not produce a fresh match edge.
  always_comb begin
    tgt_hd = alm_hd_q;
    tgt_ho = alm_ho_q;
    tgt_md = alm_md_q;
    tgt_mo = alm_mo_q;
    if (state_q == StSnooze) begin
      tgt_hd = snz_hd_q;
      tgt_ho = snz_ho_q;
      tgt_md = snz_md_q;
      tgt_mo = snz_mo_q;
    end
  end

  assign match = (hourdec_now == tgt_hd) && (hourone_now == tgt_ho) &&
                 (mindec_now == tgt_md) && (minone_now == tgt_mo);
  assign match_edge = match && !match_q;

  always_comb begin
    mo_sum = {1'b0, minone_now} + {1'b0, SnzMin};
    c_min  = (mo_sum >= 5'd10);
    add_mo = c_min ? (mo_sum[3:0] - 4'd10) : mo_sum[3:0];
    md_sum = mindec_now + {3'b000, c_min};
    c_hr   = (md_sum >= 4'd6);
    add_md = c_hr ? 4'd0 : md_sum;
    add_hd = hourdec_now;
    add_ho = hourone_now;
    if (c_hr) begin
      if ((hourdec_now == 4'd2) && (hourone_now == 4'd3)) begin
        add_hd = 4'd0;
        add_ho = 4'd0;
      end else if (hourone_now == 4'd9) begin
        add_hd = hourdec_now + 4'd1;
        add_ho = 4'd0;
      end else begin
        add_ho = hourone_now + 4'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    alm_hd_d  = alm_hd_q;
    alm_ho_d  = alm_ho_q;
    alm_md_d  = alm_md_q;
    alm_mo_d  = alm_mo_q;
    snz_hd_d  = snz_hd_q;
    snz_ho_d  = snz_ho_q;
    snz_md_d  = snz_md_q;
    snz_mo_d  = snz_mo_q;
    snz_cnt_d = snz_cnt_q;
    set_err_d = set_load && !set_valid;

    if (load_ok) begin
      alm_hd_d = hourdec_set;
      alm_ho_d = hourone_set;
      alm_md_d = mindec_set;
      alm_mo_d = minone_set;
    end

    if (!alarm_en) begin
      state_d = StIdle;
    end else if (load_ok) begin
      state_d = StArmed;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StArmed;
        StArmed: if (match_edge) state_d = StRinging;
        StRinging: begin
          if (stp_edge) begin
            state_d = StArmed;
          end else if (snz_edge) begin
            if (snz_cnt_q < SnzMax) begin
              state_d   = StSnooze;
              snz_cnt_d = snz_cnt_q + 4'd1;
              snz_hd_d  = add_hd;
              snz_ho_d  = add_ho;
              snz_md_d  = add_md;
              snz_mo_d  = add_mo;
            end else begin
              state_d = StArmed;
            end
          end else if (timeout) begin
            state_d = StArmed;
          end
        end
        StSnooze: begin
          if (stp_edge) begin
            state_d = StArmed;
          end else if (match_edge) begin
            state_d = StRinging;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if ((state_d == StArmed) || (state_d == StIdle)) begin
      snz_cnt_d = 4'd0;
    end

    // Counter only runs while staying in RINGING, so every entry starts at zero
    if ((state_q == StRinging) && (state_d == StRinging)) begin
      ring_cnt_d = ring_cnt_q + {7'd0, tick_sec};
    end else begin
      ring_cnt_d = 8'd0;
    end

    ring_d = (state_d == StRinging);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      alm_hd_q   <= 4'd0;
      alm_ho_q   <= 4'd0;
      alm_md_q   <= 4'd0;
      alm_mo_q   <= 4'd0;
      snz_hd_q   <= 4'd0;
      snz_ho_q   <= 4'd0;
      snz_md_q   <= 4'd0;
      snz_mo_q   <= 4'd0;
      ring_cnt_q <= 8'd0;
      snz_cnt_q  <= 4'd0;
      match_q    <= 1'b0;
      snz_btn_q  <= 1'b0;
      stp_btn_q  <= 1'b0;
      ring_q     <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alm_hd_q   <= alm_hd_d;
      alm_ho_q   <= alm_ho_d;
      alm_md_q   <= alm_md_d;
      alm_mo_q   <= alm_mo_d;
      snz_hd_q   <= snz_hd_d;
      snz_ho_q   <= snz_ho_d;
      snz_md_q   <= snz_md_d;
      snz_mo_q   <= snz_mo_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      match_q    <= match;
      snz_btn_q  <= btn_snooze;
      stp_btn_q  <= btn_stop;
      ring_q     <= ring_d;
      set_err_q  <= set_err_d;
    end
  end

  assign ring        = ring_q;
  assign state       = state_q;
  assign set_err     = set_err_q;
  assign hourdec_alm = alm_hd_q;
  assign hourone_alm = alm_ho_q;
  assign mindec_alm  = alm_md_q;
  assign minone_alm  = alm_mo_q;

endmodule
